// File: rtl/gf_ops_pkg.sv
// rtl/gf_ops_pkg.sv - shared state encodings for arithmetic operator blocks
package gf_ops;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/rcs_subtractor.sv
// rtl/rcs_subtractor.sv - ripple-borrow subtractor, diff = a - b
module rcs_subtractor #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] br;

    assign br[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ br[i];
        assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end

    assign borrow = br[WIDTH];

endmodule

// File: rtl/div.sv
// rtl/div.sv - restoring shift-subtract divider, 2W/W -> W quotient and remainder
module div
    import gf_ops::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_enable,
    input  logic [2*DATA_WIDTH-1:0] in_div_dividend,
    input  logic [DATA_WIDTH-1:0]   in_div_divisor,
    output logic [DATA_WIDTH-1:0]   out_div_quotient,
    output logic [DATA_WIDTH-1:0]   out_div_remainder,
    output logic                    out_div_overflow,
    output logic                    op_finish
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    div_state_e    state, state_n;
    logic [CW-1:0] cnt;
    logic [W:0]    prem;
    logic [W-1:0]  low;
    logic [W-1:0]  dvsr;
    logic [W-1:0]  quot;

    logic [W:0]    shifted, diff, prem_n;
    logic          borrow, qbit, last, ovf_start;

    // Next dividend bit enters from the MSB of the shifting low-half register
    assign shifted   = {prem[W-1:0], low[W-1]};
    assign qbit      = ~borrow;
    assign prem_n    = borrow ? shifted : diff;
    assign last      = (cnt == CW'(W - 1));
    assign ovf_start = (in_div_dividend[2*W-1:W] >= in_div_divisor);

    rcs_subtractor #(.WIDTH(W + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvsr}),
        .diff   (diff),
        .borrow (borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (!op_enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    state_n = ovf_start ? DONE : CALC;
                CALC:    state_n = last ? DONE : CALC;
                DONE:    state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt               <= '0;
            prem              <= '0;
            low               <= '0;
            dvsr              <= '0;
            quot              <= '0;
            out_div_quotient  <= '0;
            out_div_remainder <= '0;
            out_div_overflow  <= 1'b0;
            op_finish         <= 1'b0;
        end else if (!op_enable) begin
            cnt               <= '0;
            prem              <= '0;
            low               <= '0;
            dvsr              <= '0;
            quot              <= '0;
            out_div_quotient  <= '0;
            out_div_remainder <= '0;
            out_div_overflow  <= 1'b0;
            op_finish         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dvsr <= in_div_divisor;
                    low  <= in_div_dividend[W-1:0];
                    prem <= {1'b0, in_div_dividend[2*W-1:W]};
                    cnt  <= '0;
                    quot <= '0;
                    // High half >= divisor also covers divide-by-zero
                    if (ovf_start) begin
                        out_div_quotient  <= '1;
                        out_div_remainder <= '0;
                        out_div_overflow  <= 1'b1;
                        op_finish         <= 1'b1;
                    end
                end
                CALC: begin
                    prem <= prem_n;
                    low  <= {low[W-2:0], 1'b0};
                    quot <= {quot[W-2:0], qbit};
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        out_div_quotient  <= {quot[W-2:0], qbit};
                        out_div_remainder <= prem_n[W-1:0];
                        out_div_overflow  <= 1'b0;
                        op_finish         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
